vga_console_wr: RTL and testbench
=================================

VGA_CONSOLE_WR -- requirements
Module: vga_console_wr

Interface
REQ-001 Parameters SHALL be:
- COLS, default 80, characters per row.
- ROWS, default 25, rows per screen.
- ADDR_W, default 11, VRAM/CRAM address width; must satisfy COLS*ROWS <= 2**ADDR_W.
- BLINK_DIV, default 12_587_500, cursor blink half-period in clocks.
- CLS_CHAR, default 8'h20, fill character for clear.
- CLS_ATTR, default 8'h07, fill attribute for clear.
- CLS_ON_RESET, default 1, start a clear automatically after reset.

REQ-002 Ports SHALL be (name, direction, width, meaning; clock and reset first):
- i_clk, in, 1, pixel clock; the only clock.
- i_rst_h, in, 1, synchronous active-high reset.
- i_char_data, in, 8, character/control code.
- i_char_attr, in, 8, colour attribute for the character.
- i_char_valid_h, in, 1, character offered.
- o_char_ready_h, out, 1, character accepted when high together with valid.
- i_cls_h, in, 1, clear-screen request, level-sampled.
- i_blink_en_h, in, 1, 1 = cursor blinks, 0 = cursor steady on.
- o_vram_adr, out, ADDR_W, write address shared by VRAM and CRAM.
- o_vram_data, out, 8, character byte.
- o_cram_data, out, 8, attribute byte.
- o_vram_we, out, 1, one-cycle write strobe.
- o_cursor_adr, out, ADDR_W, linear cursor position.
- o_cursor_on, out, 1, cursor visible.
- o_busy_h, out, 1, clear in progress.

REQ-003 One clock (i_clk); reset i_rst_h is synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, CLS and CLS_DONE.

REQ-005 o_char_ready_h SHALL equal (state==IDLE) & ~i_cls_h. A character is accepted on a clock edge where valid & ready.

REQ-006 The cursor SHALL be held as row (0..ROWS-1), col (0..COLS-1) and a linear address row*COLS+col, updated incrementally with no multiplier. o_cursor_adr SHALL be the registered linear address.

REQ-007 Printable codes (8'h20..8'hFF) accepted at edge N SHALL produce the following in the cycle after N, with all outputs registered:
- o_vram_we=1 for exactly one cycle.
- o_vram_adr = cursor before the edge.
- o_vram_data = i_char_data and o_cram_data = i_char_attr.
- Cursor then advances by one.

REQ-008 Cursor advance SHALL follow these rules:
- If col==COLS-1: col=0, row+1.
- If row==ROWS-1 as well: wrap to row 0, address 0. There is no scrolling.

REQ-009 Control codes SHALL produce no write:
- 8'h0D (CR): col=0.
- 8'h0A (LF): row+1, wrapping to 0 after ROWS-1; col is unchanged.
- 8'h08 (BS): col-1 if col>0, else no change.
- 8'h0C (FF): same effect as i_cls_h.
- Any other code below 8'h20: ignored.

REQ-010 Back-to-back accepted characters SHALL sustain one write per clock.

REQ-011 IDLE -> CLS SHALL occur on i_cls_h=1 or on an accepted FF. In CLS, the block SHALL:
- Write CLS_CHAR/CLS_ATTR to addresses 0..COLS*ROWS-1, one per clock, in ascending order.
- Hold o_busy_h=1 and o_char_ready_h=0.

REQ-012 After the write to COLS*ROWS-1, the FSM SHALL go CLS -> CLS_DONE for one cycle: cursor := 0, o_busy_h drops, then -> IDLE.

REQ-013 i_cls_h asserted while in CLS SHALL be ignored; the clear is not restarted. i_cls_h and a valid character in the same IDLE cycle: the clear wins and the character is not accepted.

REQ-014 Blink behaviour:
- A BLINK_DIV-cycle counter SHALL toggle a blink phase.
- o_cursor_on = phase when i_blink_en_h=1, else 1.
- o_cursor_on is forced to 0 during CLS/CLS_DONE.
- Each accepted character SHALL reset the counter and set phase=1, so the cursor is visible while typing.

REQ-015 Addresses in the range COLS*ROWS..2**ADDR_W-1 SHALL never be driven with o_vram_we=1.

Reset
REQ-016 On i_rst_h=1 at a clock edge, the block SHALL set:
- o_vram_we=0, o_vram_adr=0, o_vram_data=0, o_cram_data=0.
- Cursor 0, blink counter 0, phase 1, o_cursor_on=0, o_busy_h=0.

REQ-017 While i_rst_h=1, o_char_ready_h SHALL be 0.

REQ-018 Exit from reset SHALL go to CLS if CLS_ON_RESET=1, else to IDLE.

REQ-019 Reset asserted mid-CLS SHALL abort the clear immediately. No further writes occur until reset is released.

Verification
REQ-020 The bench SHALL cover these directed scenarios (COLS=80, ROWS=25, CLS_ON_RESET=0, BLINK_DIV=4):
- Reset, then send 'A' (8'h41) with attr 8'h1E -> one cycle later we=1, adr=0, data=8'h41, cram=8'h1E; cursor_adr=1.
- Cursor at 79, send 'Z' then CR then LF -> write at adr 79; cursor goes 80 -> 80 -> 160.
- Cursor at 1999, send 'x' -> write at adr 1999; cursor wraps to 0.
- Assert i_cls_h for one cycle -> exactly 2000 consecutive writes of 8'h20/8'h07 at adr 0..1999; busy high for 2001 cycles; cursor=0; ready returns high.
- Reset asserted at clear write #500 -> we=0 on the next cycle; no write after release; busy=0.
- i_blink_en_h=1 with no input -> o_cursor_on toggles every 4 cycles; a char accept forces o_cursor_on=1 for the next 4 cycles; BS at col 0 -> no write, cursor unchanged.

Source files
------------

// File: rtl/vga_console_wr.sv
// Text-console writer: turns a character stream into VRAM/CRAM writes.
// It tracks the cursor, runs a full-screen clear and generates the cursor blink.
module vga_console_wr #(
  parameter int         COLS         = 80,
  parameter int         ROWS         = 25,
  parameter int         ADDR_W       = 11,
  parameter int         BLINK_DIV    = 12_587_500,
  parameter logic [7:0] CLS_CHAR     = 8'h20,
  parameter logic [7:0] CLS_ATTR     = 8'h07,
  parameter bit         CLS_ON_RESET = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_h,
  input  logic [7:0]        i_char_data,
  input  logic [7:0]        i_char_attr,
  input  logic              i_char_valid_h,
  output logic              o_char_ready_h,
  input  logic              i_cls_h,
  input  logic              i_blink_en_h,
  output logic [ADDR_W-1:0] o_vram_adr,
  output logic [7:0]        o_vram_data,
  output logic [7:0]        o_cram_data,
  output logic              o_vram_we,
  output logic [ADDR_W-1:0] o_cursor_adr,
  output logic              o_cursor_on,
  output logic              o_busy_h
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ADR_LAST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] ADR_ROW  = ADDR_W'(COLS);
  localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLINK_DIV - 1);

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLS      = 2'd1,
    CLS_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ADDR_W-1:0]   cur_adr_q, cur_adr_d;
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                phase_q, phase_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [7:0]          data_q, data_d;
  logic [7:0]          attr_q, attr_d;
  logic                cursor_on_q, cursor_on_d;
  logic                busy_q, busy_d;
  logic                ready;
  logic                accept;

  // pend_q carries the post-reset clear request into the first IDLE cycle,
  // so reset itself never shows a busy or writing block.
  assign ready  = (state_q == IDLE) & ~i_cls_h & ~pend_q & ~i_rst_h;
  assign accept = ready & i_char_valid_h;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    clr_cnt_d   = clr_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    cur_adr_d   = cur_adr_q;
    blk_cnt_d   = blk_cnt_q;
    phase_d     = phase_q;
    we_d        = 1'b0;
    adr_d       = adr_q;
    data_d      = data_q;
    attr_d      = attr_q;
    cursor_on_d = cursor_on_q;
    busy_d      = busy_q;

    if (blk_cnt_q == BLK_LAST) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end else begin
      blk_cnt_d = blk_cnt_q + BLK_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (i_cls_h || pend_q) begin
          state_d   = CLS;
          clr_cnt_d = '0;
          pend_d    = 1'b0;
        end else if (accept) begin
          // Typing keeps the cursor visible.
          blk_cnt_d = '0;
          phase_d   = 1'b1;
          if (i_char_data >= 8'h20) begin
            we_d   = 1'b1;
            adr_d  = cur_adr_q;
            data_d = i_char_data;
            attr_d = i_char_attr;
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                row_d     = '0;
                cur_adr_d = '0;
              end else begin
                row_d     = row_q + ROW_W'(1);
                cur_adr_d = cur_adr_q + ADDR_W'(1);
              end
            end else begin
              col_d     = col_q + COL_W'(1);
              cur_adr_d = cur_adr_q + ADDR_W'(1);
            end
          end else begin
            case (i_char_data)
              CODE_CR: begin
                col_d     = '0;
                cur_adr_d = cur_adr_q - ADDR_W'(col_q);
              end
              CODE_LF: begin
                if (row_q == ROW_LAST) begin
                  row_d     = '0;
                  cur_adr_d = ADDR_W'(col_q);
                end else begin
                  row_d     = row_q + ROW_W'(1);
                  cur_adr_d = cur_adr_q + ADR_ROW;
                end
              end
              CODE_BS: begin
                if (col_q != '0) begin
                  col_d     = col_q - COL_W'(1);
                  cur_adr_d = cur_adr_q - ADDR_W'(1);
                end
              end
              CODE_FF: begin
                state_d   = CLS;
                clr_cnt_d = '0;
              end
              default: ;
            endcase
          end
        end
      end

      CLS: begin
        we_d   = 1'b1;
        adr_d  = clr_cnt_q;
        data_d = CLS_CHAR;
        attr_d = CLS_ATTR;
        if (clr_cnt_q == ADR_LAST) begin
          state_d = CLS_DONE;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end

      CLS_DONE: begin
        row_d     = '0;
        col_d     = '0;
        cur_adr_d = '0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    cursor_on_d = (state_d != IDLE) ? 1'b0 : (i_blink_en_h ? phase_d : 1'b1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_h) begin
      state_q     <= IDLE;
      pend_q      <= CLS_ON_RESET;
      clr_cnt_q   <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cur_adr_q   <= '0;
      blk_cnt_q   <= '0;
      phase_q     <= 1'b1;
      we_q        <= 1'b0;
      adr_q       <= '0;
      data_q      <= '0;
      attr_q      <= '0;
      cursor_on_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      clr_cnt_q   <= clr_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cur_adr_q   <= cur_adr_d;
      blk_cnt_q   <= blk_cnt_d;
      phase_q     <= phase_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      data_q      <= data_d;
      attr_q      <= attr_d;
      cursor_on_q <= cursor_on_d;
      busy_q      <= busy_d;
    end
  end

  assign o_char_ready_h = ready;
  assign o_vram_we      = we_q;
  assign o_vram_adr     = adr_q;
  assign o_vram_data    = data_q;
  assign o_cram_data    = attr_q;
  assign o_cursor_adr   = cur_adr_q;
  assign o_cursor_on    = cursor_on_q;
  assign o_busy_h       = busy_q;

endmodule

// File: tb/tb_vga_console_wr.sv
// Directed bench for vga_console_wr on an 80x25 screen with a 4-cycle blink.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_vga_console_wr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_data = '0;
  logic [7:0]  char_attr = '0;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic        cls = 1'b0;
  logic        blink_en = 1'b0;
  logic [10:0] vram_adr;
  logic [7:0]  vram_data;
  logic [7:0]  cram_data;
  logic        vram_we;
  logic [10:0] cursor_adr;
  logic        cursor_on;
  logic        busy;

  int checks = 0;
  int errors = 0;

  vga_console_wr #(
    .COLS(80), .ROWS(25), .ADDR_W(11), .BLINK_DIV(4),
    .CLS_CHAR(8'h20), .CLS_ATTR(8'h07), .CLS_ON_RESET(1'b0)
  ) dut (
    .i_clk(clk), .i_rst_h(rst),
    .i_char_data(char_data), .i_char_attr(char_attr),
    .i_char_valid_h(char_valid), .o_char_ready_h(char_ready),
    .i_cls_h(cls), .i_blink_en_h(blink_en),
    .o_vram_adr(vram_adr), .o_vram_data(vram_data), .o_cram_data(cram_data),
    .o_vram_we(vram_we), .o_cursor_adr(cursor_adr), .o_cursor_on(cursor_on),
    .o_busy_h(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted character; outputs are sampled in the cycle after acceptance.
  task automatic send(input logic [7:0] d, input logic [7:0] a);
    char_data  = d;
    char_attr  = a;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    $display("tx data=%h attr=%h -> we=%0d adr=%0d cursor=%0d", d, a, vram_we, vram_adr, cursor_adr);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", vram_we); end
    checks++; if (vram_adr !== 11'd0) begin errors++; $display("FAIL reset_adr: got %0d expected 0", vram_adr); end
    checks++; if (vram_data !== 8'h00 || cram_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h/%h expected 00/00", vram_data, cram_data); end
    checks++; if (cursor_adr !== 11'd0) begin errors++; $display("FAIL reset_cursor: got %0d expected 0", cursor_adr); end
    checks++; if (cursor_on !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_on_busy: got %b/%b expected 0/0", cursor_on, busy); end
    checks++; if (char_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", char_ready); end
    rst = 1'b0;
    #1;
    checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", char_ready); end
    $display("test_reset done");
  endtask

  task automatic test_first_char();
    send(8'h41, 8'h1E);
    checks++; if (vram_we !== 1'b1 || vram_adr !== 11'd0) begin errors++; $display("FAIL char_a_write: got we=%b adr=%0d expected we=1 adr=0", vram_we, vram_adr); end
    checks++; if (vram_data !== 8'h41 || cram_data !== 8'h1E) begin errors++; $display("FAIL char_a_data: got %h/%h expected 41/1e", vram_data, cram_data); end
    checks++; if (cursor_adr !== 11'd1) begin errors++; $display("FAIL char_a_cursor: got %0d expected 1", cursor_adr); end
    checks++; if (cursor_on !== 1'b1) begin errors++; $display("FAIL char_a_cursor_on: got %b expected 1", cursor_on); end
    tick();
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL char_a_one_shot: got %b expected 0", vram_we); end
  endtask

  // Fills addresses 1..78 with one write per clock, then Z at 79, CR, LF.
  task automatic test_back_to_back();
    int bad = 0;
    char_valid = 1'b1;
    char_attr  = 8'h2A;
    for (int i = 0; i < 78; i++) begin
      char_data = 8'h30 + 8'(i % 10);
      tick();
      if (vram_we !== 1'b1 || vram_adr !== 11'(1 + i) || vram_data !== 8'h30 + 8'(i % 10) || cram_data !== 8'h2A) bad++;
    end
    char_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL burst_writes: got %0d bad cycles expected 0", bad); end
    checks++; if (cursor_adr !== 11'd79) begin errors++; $display("FAIL burst_cursor: got %0d expected 79", cursor_adr); end
    send(8'h5A, 8'h0F);
    checks++; if (vram_we !== 1'b1 || vram_adr !== 11'd79 || vram_data !== 8'h5A) begin errors++; $display("FAIL z_write: got we=%b adr=%0d data=%h expected 1/79/5a", vram_we, vram_adr, vram_data); end
    checks++; if (cursor_adr !== 11'd80) begin errors++; $display("FAIL z_cursor: got %0d expected 80", cursor_adr); end
    send(8'h0D, 8'h00);
    checks++; if (vram_we !== 1'b0 || cursor_adr !== 11'd80) begin errors++; $display("FAIL cr: got we=%b cursor=%0d expected 0/80", vram_we, cursor_adr); end
    send(8'h0A, 8'h00);
    checks++; if (vram_we !== 1'b0 || cursor_adr !== 11'd160) begin errors++; $display("FAIL lf: got we=%b cursor=%0d expected 0/160", vram_we, cursor_adr); end
  endtask

  task automatic test_wrap();
    int bad = 0;
    for (int i = 0; i < 22; i++) begin
      send(8'h0A, 8'h00);
      if (vram_we !== 1'b0) bad++;
    end
    checks++; if (bad !== 0 || cursor_adr !== 11'd1920) begin errors++; $display("FAIL lf_walk: got bad=%0d cursor=%0d expected 0/1920", bad, cursor_adr); end
    bad = 0;
    char_valid = 1'b1;
    char_data  = 8'h2E;
    for (int i = 0; i < 79; i++) begin
      tick();
      if (vram_we !== 1'b1 || vram_adr !== 11'(1920 + i)) bad++;
    end
    char_valid = 1'b0;
    checks++; if (bad !== 0 || cursor_adr !== 11'd1999) begin errors++; $display("FAIL last_row: got bad=%0d cursor=%0d expected 0/1999", bad, cursor_adr); end
    send(8'h78, 8'h4C);
    checks++; if (vram_we !== 1'b1 || vram_adr !== 11'd1999 || vram_data !== 8'h78) begin errors++; $display("FAIL x_write: got we=%b adr=%0d data=%h expected 1/1999/78", vram_we, vram_adr, vram_data); end
    checks++; if (cursor_adr !== 11'd0) begin errors++; $display("FAIL x_wrap: got %0d expected 0", cursor_adr); end
  endtask

  task automatic test_backspace();
    send(8'h62, 8'h07);
    checks++; if (cursor_adr !== 11'd1) begin errors++; $display("FAIL bs_setup: got %0d expected 1", cursor_adr); end
    send(8'h08, 8'h00);
    checks++; if (vram_we !== 1'b0 || cursor_adr !== 11'd0) begin errors++; $display("FAIL bs_step: got we=%b cursor=%0d expected 0/0", vram_we, cursor_adr); end
    send(8'h08, 8'h00);
    checks++; if (vram_we !== 1'b0 || cursor_adr !== 11'd0) begin errors++; $display("FAIL bs_col0: got we=%b cursor=%0d expected 0/0", vram_we, cursor_adr); end
    send(8'h01, 8'h00);
    checks++; if (vram_we !== 1'b0 || cursor_adr !== 11'd0) begin errors++; $display("FAIL ctrl_ignored: got we=%b cursor=%0d expected 0/0", vram_we, cursor_adr); end
    send(8'h63, 8'h07);
  endtask

  // Clear with a competing character, and a second clear request mid-way.
  task automatic test_cls();
    int bad = 0;
    int busy_cycles = 0;
    cls        = 1'b1;
    char_valid = 1'b1;
    char_data  = 8'h51;
    #1;
    checks++; if (char_ready !== 1'b0) begin errors++; $display("FAIL cls_ready: got %b expected 0", char_ready); end
    tick();
    cls        = 1'b0;
    char_valid = 1'b0;
    checks++; if (vram_we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL cls_start: got we=%b busy=%b expected 0/1", vram_we, busy); end
    if (busy === 1'b1) busy_cycles++;
    for (int k = 0; k < 2000; k++) begin
      cls = (k == 100);
      tick();
      if (vram_we !== 1'b1 || vram_adr !== 11'(k) || vram_data !== 8'h20 || cram_data !== 8'h07 || char_ready !== 1'b0 || cursor_on !== 1'b0) bad++;
      if (busy === 1'b1) busy_cycles++;
    end
    cls = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL cls_writes: got %0d bad cycles expected 0", bad); end
    tick();
    if (busy === 1'b1) busy_cycles++;
    checks++; if (busy_cycles !== 2001) begin errors++; $display("FAIL cls_busy_len: got %0d expected 2001", busy_cycles); end
    checks++; if (busy !== 1'b0 || vram_we !== 1'b0) begin errors++; $display("FAIL cls_end: got busy=%b we=%b expected 0/0", busy, vram_we); end
    checks++; if (cursor_adr !== 11'd0 || char_ready !== 1'b1 || cursor_on !== 1'b1) begin errors++; $display("FAIL cls_idle: got cursor=%0d ready=%b on=%b expected 0/1/1", cursor_adr, char_ready, cursor_on); end
    $display("test_cls done: %0d busy cycles", busy_cycles);
  endtask

  task automatic test_reset_mid_clear();
    int writes = 0;
    send(8'h0C, 8'h00);
    checks++; if (vram_we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ff_start: got we=%b busy=%b expected 0/1", vram_we, busy); end
    for (int k = 0; k < 501; k++) tick();
    checks++; if (vram_we !== 1'b1 || vram_adr !== 11'd500) begin errors++; $display("FAIL ff_write500: got we=%b adr=%0d expected 1/500", vram_we, vram_adr); end
    rst = 1'b1;
    tick();
    checks++; if (vram_we !== 1'b0 || busy !== 1'b0 || char_ready !== 1'b0) begin errors++; $display("FAIL abort: got we=%b busy=%b ready=%b expected 0/0/0", vram_we, busy, char_ready); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (vram_we === 1'b1 || busy === 1'b1) writes++;
    end
    checks++; if (writes !== 0) begin errors++; $display("FAIL after_abort: got %0d active cycles expected 0", writes); end
    checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", char_ready); end
  endtask

  task automatic test_blink();
    logic exp;
    int bad = 0;
    blink_en = 1'b1;
    send(8'h6B, 8'h07);
    for (int k = 0; k < 6; k++) begin
      exp = (k < 4);
      if (cursor_on !== exp) begin
        bad++;
        $display("FAIL blink_free[%0d]: got %b expected %b", k, cursor_on, exp);
      end
      if (k < 5) tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL blink_free: got %0d bad cycles expected 0", bad); end
    bad = 0;
    send(8'h6C, 8'h07);
    for (int k = 0; k < 5; k++) begin
      exp = (k < 4);
      if (cursor_on !== exp) begin
        bad++;
        $display("FAIL blink_typing[%0d]: got %b expected %b", k, cursor_on, exp);
      end
      if (k < 4) tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL blink_typing: got %0d bad cycles expected 0", bad); end
    blink_en = 1'b0;
    tick();
    checks++; if (cursor_on !== 1'b1) begin errors++; $display("FAIL blink_off: got %b expected 1", cursor_on); end
  endtask

  initial begin
    test_reset();
    test_first_char();
    test_back_to_back();
    test_wrap();
    test_backspace();
    test_cls();
    test_reset_mid_clear();
    test_blink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
